// File: rtl/pwm_breath_ctrl.sv
// pwm_breath_ctrl: prescaled PWM sequencer with valid/ready config shadowed to period boundaries.
// Define PWM_BREATH_EN to build the breathe (duty ramp up/down) mode; otherwise fixed duty only.
module pwm_breath_ctrl #(
   parameter int unsigned PRESCALE  = 10,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk_in_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [CNT_WIDTH-1:0] cfg_period_i,
   input  logic [CNT_WIDTH-1:0] cfg_duty_i,
   input  logic [CNT_WIDTH-1:0] cfg_step_i,
   input  logic                 cfg_mode_i,
   output logic                 pwm_o,
   output logic                 busy_o,
   output logic                 period_end_o,
   output logic [CNT_WIDTH-1:0] duty_o
);

   localparam int unsigned     PreW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRunFix,
      StRunUp,
      StRunDown,
      StDrain
   } state_e;

   state_e               state_q, state_d;
   logic [PreW-1:0]      pre_q, pre_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] duty_cur_q, duty_cur_d;
   logic [CNT_WIDTH-1:0] per_q, per_d;
   logic [CNT_WIDTH-1:0] ceil_q, ceil_d;
   logic                 mode_q, mode_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [CNT_WIDTH-1:0] pend_per_q, pend_per_d;
   logic [CNT_WIDTH-1:0] pend_duty_q, pend_duty_d;
   logic                 pend_mode_q, pend_mode_d;
   logic                 pwm_q, pwm_d;
   logic                 period_end_q, period_end_d;

   logic                 tick;
   logic                 at_period_end;
   logic                 accept;
   logic                 apply_cfg;
   logic                 start_ok;
   logic                 in_mode;
   state_e               ramp_state;
   logic [CNT_WIDTH-1:0] ramp_duty;

   assign tick          = (state_q != StIdle) && (pre_q == PreMax);
   assign at_period_end = tick && (cnt_q == per_q);
   assign accept        = cfg_valid_i && !pend_valid_q;
   // Pending words land immediately when idle, otherwise only on a period boundary.
   assign apply_cfg     = pend_valid_q && ((state_q == StIdle) || at_period_end);
   assign start_ok      = start_i && !stop_i;

`ifdef PWM_BREATH_EN
   logic [CNT_WIDTH-1:0] step_q, step_d;
   logic [CNT_WIDTH-1:0] pend_step_q, pend_step_d;
   logic [CNT_WIDTH:0]   ramp_sum;

   assign in_mode = cfg_mode_i;

   always_comb begin
      step_d      = apply_cfg ? pend_step_q : step_q;
      pend_step_d = accept ? cfg_step_i : pend_step_q;
      ramp_sum    = {1'b0, duty_cur_q} + {1'b0, step_q};
      ramp_state  = state_q;
      ramp_duty   = duty_cur_q;
      case (state_q)
         StRunUp: begin
            // Sum is one bit wider so an overflowing step still clamps to the ceiling.
            if (ramp_sum >= {1'b0, ceil_q}) begin
               ramp_state = StRunDown;
               ramp_duty  = ceil_q;
            end else begin
               ramp_duty = ramp_sum[CNT_WIDTH-1:0];
            end
         end
         StRunDown: begin
            if (duty_cur_q <= step_q) begin
               ramp_state = StRunUp;
               ramp_duty  = '0;
            end else begin
               ramp_duty = duty_cur_q - step_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in_i or posedge rst_i) begin
      if (rst_i) begin
         step_q      <= '0;
         pend_step_q <= '0;
      end else begin
         step_q      <= step_d;
         pend_step_q <= pend_step_d;
      end
   end
`else
   logic unused_breath_cfg;
   assign unused_breath_cfg = ^{cfg_mode_i, cfg_step_i};
   assign in_mode           = 1'b0;
   assign ramp_state        = state_q;
   assign ramp_duty         = duty_cur_q;
`endif

   always_comb begin
      state_d      = state_q;
      pre_d        = pre_q;
      cnt_d        = cnt_q;
      duty_cur_d   = duty_cur_q;
      per_d        = per_q;
      ceil_d       = ceil_q;
      mode_d       = mode_q;
      pend_valid_d = pend_valid_q;
      pend_per_d   = pend_per_q;
      pend_duty_d  = pend_duty_q;
      pend_mode_d  = pend_mode_q;
      period_end_d = at_period_end;

      if (accept) begin
         pend_valid_d = 1'b1;
         pend_per_d   = cfg_period_i;
         pend_duty_d  = cfg_duty_i;
         pend_mode_d  = in_mode;
      end
      if (apply_cfg) begin
         pend_valid_d = 1'b0;
         per_d        = pend_per_q;
         ceil_d       = pend_duty_q;
         mode_d       = pend_mode_q;
      end

      if ((state_q == StIdle) || tick) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + 1'b1;
      end

      if (tick) begin
         cnt_d = at_period_end ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = mode_d ? StRunUp : StRunFix;
               cnt_d   = '0;
            end
            if (apply_cfg || start_ok) begin
               duty_cur_d = mode_d ? '0 : ceil_d;
            end
         end
         StRunFix, StRunUp, StRunDown: begin
            if (at_period_end) begin
               if (apply_cfg) begin
                  state_d    = mode_d ? StRunUp : StRunFix;
                  duty_cur_d = mode_d ? '0 : ceil_d;
               end else begin
                  state_d    = ramp_state;
                  duty_cur_d = ramp_duty;
               end
            end
            if (stop_i) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (at_period_end) begin
               state_d = StIdle;
               if (apply_cfg) begin
                  duty_cur_d = mode_d ? '0 : ceil_d;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Computed from next-state values so pwm_o always matches the registered cnt/duty pair.
      pwm_d = (state_d != StIdle) && (cnt_d < duty_cur_d);
   end

   always_ff @(posedge clk_in_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         pre_q        <= '0;
         cnt_q        <= '0;
         duty_cur_q   <= '0;
         per_q        <= '0;
         ceil_q       <= '0;
         mode_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_per_q   <= '0;
         pend_duty_q  <= '0;
         pend_mode_q  <= 1'b0;
         pwm_q        <= 1'b0;
         period_end_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         cnt_q        <= cnt_d;
         duty_cur_q   <= duty_cur_d;
         per_q        <= per_d;
         ceil_q       <= ceil_d;
         mode_q       <= mode_d;
         pend_valid_q <= pend_valid_d;
         pend_per_q   <= pend_per_d;
         pend_duty_q  <= pend_duty_d;
         pend_mode_q  <= pend_mode_d;
         pwm_q        <= pwm_d;
         period_end_q <= period_end_d;
      end
   end

   assign cfg_ready_o  = !pend_valid_q;
   assign pwm_o        = pwm_q;
   assign busy_o       = (state_q != StIdle);
   assign period_end_o = period_end_q;
   assign duty_o       = duty_cur_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Testbench for pwm_breath_ctrl: per-clock expected observations queued at stimulus time,
// popped and compared one clock at a time. Breathe checks follow PWM_BREATH_EN.
module tb_pwm_breath_ctrl;
   localparam int Pre = 2;
   localparam int W   = 8;

   logic         clk          = 1'b0;
   logic         rst_i        = 1'b0;
   logic         start_i      = 1'b0;
   logic         stop_i       = 1'b0;
   logic         cfg_valid_i  = 1'b0;
   logic [W-1:0] cfg_period_i = '0;
   logic [W-1:0] cfg_duty_i   = '0;
   logic [W-1:0] cfg_step_i   = '0;
   logic         cfg_mode_i   = 1'b0;
   logic         cfg_ready_o;
   logic         pwm_o;
   logic         busy_o;
   logic         period_end_o;
   logic [W-1:0] duty_o;

   int n_vec = 0;
   int n_err = 0;
   logic [11:0] exp_q[$];

   pwm_breath_ctrl #(
      .PRESCALE (Pre),
      .CNT_WIDTH(W)
   ) dut (
      .clk_in_i    (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_period_i(cfg_period_i),
      .cfg_duty_i  (cfg_duty_i),
      .cfg_step_i  (cfg_step_i),
      .cfg_mode_i  (cfg_mode_i),
      .pwm_o       (pwm_o),
      .busy_o      (busy_o),
      .period_end_o(period_end_o),
      .duty_o      (duty_o)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] obs();
      return {busy_o, pwm_o, period_end_o, cfg_ready_o, duty_o};
   endfunction

   function automatic logic [11:0] mk(input logic b, input logic p, input logic e,
                                      input logic r, input logic [W-1:0] d);
      return {b, p, e, r, d};
   endfunction

   task automatic cfg_idle(input logic [W-1:0] p, input logic [W-1:0] d,
                           input logic [W-1:0] s, input logic m);
      cfg_period_i = p;
      cfg_duty_i   = d;
      cfg_step_i   = s;
      cfg_mode_i   = m;
      cfg_valid_i  = 1'b1;
      step_clk();
      cfg_valid_i  = 1'b0;
      step_clk();
   endtask

   task automatic start_run();
      start_i = 1'b1;
      step_clk();
      start_i = 1'b0;
   endtask

   task automatic stop_and_wait();
      stop_i = 1'b1;
      step_clk();
      stop_i = 1'b0;
      for (int i = 0; i < 200 && busy_o; i++) step_clk();
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL drain_timeout busy got=%b exp=0", busy_o);
      end
   endtask

   task automatic test_reset();
      logic [11:0] got, ex;
      rst_i = 1'b1;
      repeat (3) step_clk();
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL reset_held got=%h exp=%h", got, ex); end
      rst_i = 1'b0;
      step_clk();
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL reset_release got=%h exp=%h", got, ex); end
   endtask

   task automatic test_fixed();
      logic [11:0] got, ex;
      cfg_period_i = 8'd3;
      cfg_duty_i   = 8'd2;
      cfg_step_i   = 8'd0;
      cfg_mode_i   = 1'b0;
      cfg_valid_i  = 1'b1;
      step_clk();
      cfg_valid_i  = 1'b0;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL fixed_idle_pend got=%h exp=%h", got, ex); end
      step_clk();
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd2));
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL fixed_idle_apply got=%h exp=%h", got, ex); end
      start_run();
      for (int c = 0; c < 24; c++)
         exp_q.push_back(mk(1'b1, ((c / Pre) % 4) < 2, (c > 0) && (c % 8 == 0), 1'b1, 8'd2));
      for (int c = 0; c < 24; c++) begin
         got = obs(); ex = exp_q.pop_front(); n_vec++;
         if (got !== ex) begin n_err++; $display("FAIL fixed c=%0d got=%h exp=%h", c, got, ex); end
         step_clk();
      end
      stop_and_wait();
   endtask

   task automatic test_saturation();
      logic [11:0]  got, ex;
      logic [W-1:0] d;
      for (int k = 0; k < 2; k++) begin
         d = (k == 0) ? 8'd0 : 8'd4;
         cfg_idle(8'd3, d, 8'd0, 1'b0);
         start_run();
         for (int c = 0; c < 16; c++)
            exp_q.push_back(mk(1'b1, k == 1, (c > 0) && (c % 8 == 0), 1'b1, d));
         for (int c = 0; c < 16; c++) begin
            got = obs(); ex = exp_q.pop_front(); n_vec++;
            if (got !== ex) begin
               n_err++;
               $display("FAIL saturation duty=%0d c=%0d got=%h exp=%h", d, c, got, ex);
            end
            step_clk();
         end
         stop_and_wait();
      end
   endtask

   task automatic test_shadow();
      logic [11:0]  got, ex;
      logic [W-1:0] dseq [4] = '{8'd1, 8'd3, 8'd3, 8'd2};
      cfg_idle(8'd3, 8'd1, 8'd0, 1'b0);
      start_run();
      for (int c = 0; c < 28; c++)
         exp_q.push_back(mk(1'b1, ((c / Pre) % 4) < int'(dseq[c / 8]), (c > 0) && (c % 8 == 0),
                            !((c >= 3 && c <= 7) || (c >= 16 && c <= 23)), dseq[c / 8]));
      for (int c = 0; c < 28; c++) begin
         got = obs(); ex = exp_q.pop_front(); n_vec++;
         if (got !== ex) begin n_err++; $display("FAIL shadow c=%0d got=%h exp=%h", c, got, ex); end
         // Second word is offered on the period-end clock itself.
         cfg_valid_i = (c == 2) || (c == 15);
         cfg_duty_i  = (c == 15) ? 8'd2 : 8'd3;
         step_clk();
      end
      cfg_valid_i = 1'b0;
      stop_and_wait();
   endtask

   task automatic test_breathe();
      logic [11:0]  got, ex;
`ifdef PWM_BREATH_EN
      logic [W-1:0] dseq [6] = '{8'd0, 8'd3, 8'd4, 8'd1, 8'd0, 8'd3};
`else
      logic [W-1:0] dseq [6] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
`endif
      cfg_idle(8'd7, 8'd4, 8'd3, 1'b1);
      start_run();
      for (int c = 0; c < 96; c++)
         exp_q.push_back(mk(1'b1, ((c / Pre) % 8) < int'(dseq[c / 16]),
                            (c > 0) && (c % 16 == 0), 1'b1, dseq[c / 16]));
      for (int c = 0; c < 96; c++) begin
         got = obs(); ex = exp_q.pop_front(); n_vec++;
         if (got !== ex) begin n_err++; $display("FAIL breathe c=%0d got=%h exp=%h", c, got, ex); end
         step_clk();
      end
      stop_and_wait();
   endtask

   task automatic test_stop();
      logic [11:0] got, ex;
      cfg_idle(8'd3, 8'd2, 8'd0, 1'b0);
      start_run();
      for (int c = 0; c < 10; c++)
         exp_q.push_back(mk(c < 8, (c < 8) && (((c / Pre) % 4) < 2), c == 8, 1'b1, 8'd2));
      for (int c = 0; c < 10; c++) begin
         got = obs(); ex = exp_q.pop_front(); n_vec++;
         if (got !== ex) begin n_err++; $display("FAIL drain c=%0d got=%h exp=%h", c, got, ex); end
         stop_i = (c == 3);
         step_clk();
      end
      stop_i  = 1'b0;
      start_i = 1'b1;
      stop_i  = 1'b1;
      step_clk();
      start_i = 1'b0;
      stop_i  = 1'b0;
      for (int c = 0; c < 3; c++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd2));
      for (int c = 0; c < 3; c++) begin
         got = obs(); ex = exp_q.pop_front(); n_vec++;
         if (got !== ex) begin
            n_err++;
            $display("FAIL start_stop_idle c=%0d got=%h exp=%h", c, got, ex);
         end
         step_clk();
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] got, ex;
      cfg_idle(8'd3, 8'd2, 8'd0, 1'b0);
      start_run();
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'd2));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd2));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL rstmid_run got=%h exp=%h", got, ex); end
      cfg_period_i = 8'd3;
      cfg_duty_i   = 8'd3;
      cfg_valid_i  = 1'b1;
      step_clk();
      cfg_valid_i  = 1'b0;
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL rstmid_pend got=%h exp=%h", got, ex); end
      rst_i = 1'b1;
      #1;
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL rstmid_async got=%h exp=%h", got, ex); end
      #1;
      rst_i = 1'b0;
      for (int c = 0; c < 3; c++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0));
      for (int c = 0; c < 3; c++) begin
         step_clk();
         got = obs(); ex = exp_q.pop_front(); n_vec++;
         if (got !== ex) begin n_err++; $display("FAIL rstmid_idle c=%0d got=%h exp=%h", c, got, ex); end
      end
      start_run();
      got = obs(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL rstmid_restart got=%h exp=%h", got, ex); end
      stop_and_wait();
   endtask

   initial begin
      #1;
      test_reset();
      test_fixed();
      test_saturation();
      test_shadow();
      test_breathe();
      test_stop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
